seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/div_sign_fix.sv | 14 +
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } div_state_e;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned MaxWidth     = 64;

  // Iteration counter must hold the value N itself.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned CntWidth = cnt_width(DefaultWidth);

  // Quotient reported on divide-by-zero; sliced to the instance width.
  localparam logic [MaxWidth-1:0] DivZeroQ = '1;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign correction.
module div_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = neg ? (~din + W'(1)) : din;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider, one quotient bit per clock.
// SEQ_DIVIDER_SIGNED_EN selects signed operands; otherwise a, b, q, r are unsigned.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  localparam int unsigned CntW = cnt_width(N);

  if (N < 4 || N > MaxWidth) begin : g_width_check
    $error("seq_divider: N out of supported range");
  end

  div_state_e      state;
  logic [CntW-1:0] count;
  logic [N:0]      p_reg;
  logic [N-1:0]    q_reg;
  logic [N-1:0]    b_mag;
  logic            q_neg;
  logic            r_neg;
  logic            dz;

  logic            neg_a;
  logic            neg_b;
  logic [N-1:0]    a_abs;
  logic [N-1:0]    b_abs;
  logic [N:0]      p_shift;
  logic [N:0]      p_step;
  logic [N-1:0]    p_rest;
  logic [N-1:0]    q_fixed;
  logic [N-1:0]    r_fixed;

`ifdef SEQ_DIVIDER_SIGNED_EN
  always_comb begin
    neg_a = a[N-1];
    neg_b = b[N-1];
  end
`else
  always_comb begin
    neg_a = 1'b0;
    neg_b = 1'b0;
  end
`endif

  div_sign_fix #(.W(N)) u_abs_a (
    .neg  (neg_a),
    .din  (a),
    .dout (a_abs)
  );

  div_sign_fix #(.W(N)) u_abs_b (
    .neg  (neg_b),
    .din  (b),
    .dout (b_abs)
  );

  // One non-restoring step: the add/subtract choice follows the sign of P before the shift.
  always_comb begin
    p_shift = {p_reg[N-1:0], q_reg[N-1]};
    p_step  = p_reg[N] ? (p_shift + {1'b0, b_mag}) : (p_shift - {1'b0, b_mag});
    // Final remainder lies in [0, |b|), so N bits of the restore are enough.
    p_rest  = p_reg[N-1:0] + (p_reg[N] ? b_mag : '0);
  end

  div_sign_fix #(.W(N)) u_fix_q (
    .neg  (q_neg),
    .din  (q_reg),
    .dout (q_fixed)
  );

  div_sign_fix #(.W(N)) u_fix_r (
    .neg  (r_neg),
    .din  (p_rest),
    .dout (r_fixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      count <= '0;
      p_reg <= '0;
      q_reg <= '0;
      b_mag <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            busy  <= 1'b1;
            q_neg <= neg_a ^ neg_b;
            r_neg <= neg_a;
            b_mag <= b_abs;
            p_reg <= '0;
            count <= CntW'(N);
            if (b == '0) begin
              // Raw dividend is parked in Q so FIX can return it untouched.
              dz    <= 1'b1;
              q_reg <= a;
              state <= StFix;
            end else begin
              dz    <= 1'b0;
              q_reg <= a_abs;
              state <= StRun;
            end
          end
        end
        StRun: begin
          p_reg <= p_step;
          q_reg <= {q_reg[N-2:0], ~p_step[N]};
          count <= count - 1'b1;
          if (count == CntW'(1)) begin
            state <= StFix;
          end
        end
        StFix: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          dbz   <= dz;
          state <= StIdle;
          if (dz) begin
            q <= DivZeroQ[N-1:0];
            r <= q_reg;
          end else begin
            q <= q_fixed;
            r <= r_fixed;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=32); expectations follow SEQ_DIVIDER_SIGNED_EN.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;

  int errors;
  int checks;

  seq_divider #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one division and wait (bounded) for done; returns at posedge+1 of the done cycle.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, output logic [31:0] oq,
                       output logic [31:0] orr, output logic odbz, output logic obusy,
                       output int lat);
    @(negedge clk);
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    oq    = q;
    orr   = r;
    odbz  = dbz;
    obusy = busy;
  endtask

  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic edbz);
    longint xa, xb, tq, tr;
`ifdef SEQ_DIVIDER_SIGNED_EN
    xa = longint'($signed(ma));
    xb = longint'($signed(mb));
`else
    xa = longint'({32'd0, ma});
    xb = longint'({32'd0, mb});
`endif
    if (mb == 32'd0) begin
      eq   = 32'hFFFF_FFFF;
      er   = ma;
      edbz = 1'b1;
    end else begin
      tq   = xa / xb;
      tr   = xa % xb;
      eq   = tq[31:0];
      er   = tr[31:0];
      edbz = 1'b0;
    end
  endfunction

  initial begin
    logic [31:0] rq, rr, eq, er;
    logic        rdbz, rbusy, edbz;
    int          lat, pulses, guard;

    errors = 0;
    checks = 0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[0]  = '{"pos",      32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{"neg_a",    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{"neg_b",    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 33};
    vecs[3]  = '{"small",    32'd7,        32'hFFFFFF9C, 32'd0,        32'd7,        1'b0, 33};
    vecs[5]  = '{"ovf",      32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[6]  = '{"both_neg", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
`else
    vecs[0]  = '{"pos",      32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{"neg_a",    32'hFFFFFF9C, 32'd7,        32'h24924916, 32'd2,        1'b0, 33};
    vecs[2]  = '{"neg_b",    32'd100,      32'hFFFFFFF9, 32'd0,        32'd100,      1'b0, 33};
    vecs[3]  = '{"small",    32'd7,        32'hFFFFFF9C, 32'd0,        32'd7,        1'b0, 33};
    vecs[5]  = '{"ovf",      32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
    vecs[6]  = '{"both_neg", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd0,        32'hFFFFFF9C, 1'b0, 33};
`endif
    vecs[4]  = '{"dbz",      32'd55,       32'd0,        32'hFFFFFFFF, 32'd55,       1'b1, 1};
    vecs[7]  = '{"dbz_neg",  32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
    vecs[8]  = '{"big",      32'd12345678, 32'd1000,     32'd12345,    32'd678,      1'b0, 33};
    vecs[9]  = '{"zero_a",   32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 33};
    vecs[10] = '{"all1_by1", 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[11] = '{"exact",    32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        32'd0,        1'b0, 33};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #7;
    chk("reset_outputs", {27'd0, busy, done, dbz, 2'b00}, 32'd0);
    chk("reset_q", q, 32'd0);
    chk("reset_r", r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: each op starts in the previous op's done cycle.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, rq, rr, rdbz, rbusy, lat);
      chk($sformatf("%s_q", vecs[i].name), rq, vecs[i].q);
      chk($sformatf("%s_r", vecs[i].name), rr, vecs[i].r);
      chk($sformatf("%s_dbz", vecs[i].name), {31'd0, rdbz}, {31'd0, vecs[i].dbz});
      chk($sformatf("%s_lat", vecs[i].name), lat, vecs[i].lat);
      chk($sformatf("%s_busy_at_done", vecs[i].name), {31'd0, rbusy}, 32'd0);
    end

    // Results hold after done.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", q, 32'd1);
    chk("hold_done_low", {31'd0, done}, 32'd0);

    // start held high across the whole operation gives one done within the first op window.
    @(negedge clk);
    a      = 32'd100;
    b      = 32'd7;
    start  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    start = 1'b0;
    chk("held_start_pulses", pulses, 1);
    chk("held_start_busy", {31'd0, busy}, 32'd1);
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("held_start_drain", {31'd0, busy}, 32'd0);
    chk("held_start_q", q, 32'd14);

    // Reset during RUN: outputs clear at once, no done follows.
    do_op(32'd100, 32'd7, rq, rr, rdbz, rbusy, lat);
    @(negedge clk);
    a     = 32'd1000;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {29'd0, busy, done, dbz}, 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    do_op(32'd1000, 32'd3, rq, rr, rdbz, rbusy, lat);
    chk("after_rst_q", rq, 32'd333);
    chk("after_rst_r", rr, 32'd1);
    chk("after_rst_lat", lat, 33);

    // Random pairs against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> $urandom_range(31, 0);
      if (i % 4 == 1) ra = ra >> $urandom_range(31, 0);
      if (i % 50 == 7) rb = 32'd0;
      model(ra, rb, eq, er, edbz);
      do_op(ra, rb, rq, rr, rdbz, rbusy, lat);
      chk($sformatf("rnd%0d_q", i), rq, eq);
      chk($sformatf("rnd%0d_r", i), rr, er);
      chk($sformatf("rnd%0d_dbz", i), {31'd0, rdbz}, {31'd0, edbz});
      chk($sformatf("rnd%0d_lat", i), lat, (rb == 32'd0) ? 1 : 33);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
